// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the five-stage MIPS pipeline.
//
// Owns the fetch PC, issues one word read at a time on an SRAM-like
// instruction bus, buffers the returned instruction until decode accepts it,
// and applies branch/jump redirects (honouring the delay slot) as well as
// exception redirects.
//
// Ports
//   clk, resetn        : clock (rising edge) and asynchronous active-low reset
//   inst_req           : bus read request (address phase)
//   inst_wr            : always 0 (reads only)
//   inst_size          : always 2'b10 (word)
//   inst_addr          : request address, equal to the fetch PC
//   inst_addr_ok       : slave accepted the address (handshake = req & addr_ok)
//   inst_data_ok       : read data valid on inst_rdata
//   inst_rdata         : read data
//   if_valid           : if_pc / if_inst / if_adel hold a valid entry
//   if_pc, if_inst     : PC and instruction word of the buffered entry
//   if_adel            : buffered entry is a misaligned fetch (if_inst = 0)
//   id_allowin         : decode accepts; transfer = if_valid & id_allowin
//   id_br_fire         : a branch/jump leaves decode this cycle
//   id_jump, id_target : branch taken and its target PC
//   exc_flush, exc_pc  : exception redirect pulse and redirect PC
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel,
    input  logic        id_allowin,
    input  logic        id_br_fire,
    input  logic        id_jump,
    input  logic [31:0] id_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic        br_pending;
    logic [31:0] br_target;

    logic        misaligned;
    logic        addr_hs;
    logic        transfer;
    logic        take_branch;
    logic [31:0] next_seq_pc;

    assign misaligned  = (fetch_pc[1:0] != 2'b00);
    assign inst_req    = (state == S_REQ) && !misaligned;
    assign inst_wr     = 1'b0;
    assign inst_size   = 2'b10;
    assign inst_addr   = fetch_pc;
    assign addr_hs     = inst_req && inst_addr_ok;
    assign transfer    = if_valid && id_allowin;
    assign take_branch = id_br_fire && id_jump;

    // A branch taken in the very cycle the delay slot leaves wins over an
    // older pending target; otherwise fall through sequentially.
    assign next_seq_pc = take_branch ? id_target :
                         br_pending  ? br_target :
                                       fetch_pc + 32'd4;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A flush must not leave an accepted read unanswered,
    // so any read already handed to the slave is drained before refetching.
    always_comb begin
        state_next = state;
        if (exc_flush) begin
            case (state)
                S_IDLE:  state_next = S_REQ;
                S_REQ:   state_next = addr_hs ? S_DRAIN : S_REQ;
                S_WAIT:  state_next = inst_data_ok ? S_REQ : S_DRAIN;
                S_HOLD:  state_next = S_REQ;
                S_DRAIN: state_next = S_DRAIN;
                default: state_next = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE:  state_next = S_REQ;
                S_REQ: begin
                    if (misaligned) begin
                        state_next = S_HOLD;
                    end else if (addr_hs) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT:  if (inst_data_ok) state_next = S_HOLD;
                S_HOLD:  if (transfer)     state_next = S_REQ;
                S_DRAIN: if (inst_data_ok) state_next = S_REQ;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Fetch PC, pending-branch record and the output buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc   <= RESET_PC;
            br_pending <= 1'b0;
            br_target  <= 32'd0;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_inst    <= 32'd0;
            if_adel    <= 1'b0;
        end else if (exc_flush) begin
            fetch_pc   <= exc_pc;
            br_pending <= 1'b0;
            if_valid   <= 1'b0;
            if_adel    <= 1'b0;
        end else begin
            // Misaligned PC: synthesise an address-error entry without a bus read.
            if (state == S_REQ && misaligned) begin
                if_pc    <= fetch_pc;
                if_inst  <= 32'd0;
                if_adel  <= 1'b1;
                if_valid <= 1'b1;
            end
            if (state == S_WAIT && inst_data_ok) begin
                if_pc    <= fetch_pc;
                if_inst  <= inst_rdata;
                if_adel  <= 1'b0;
                if_valid <= 1'b1;
            end
            // The taken branch is remembered until the delay slot has been
            // handed to decode, then becomes the next fetch address.
            if (state == S_HOLD && transfer) begin
                if_valid   <= 1'b0;
                fetch_pc   <= next_seq_pc;
                br_pending <= 1'b0;
            end else if (take_branch) begin
                br_pending <= 1'b1;
                br_target  <= id_target;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : scoreboard bench for if_stage.
// Directed stimulus pushes the expected bus request addresses and expected
// decode-side entries into queues; a monitor pops and compares them whenever
// the DUT performs an address handshake or a transfer toward decode.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        id_allowin;
    logic        id_br_fire;
    logic        id_jump;
    logic [31:0] id_target;
    logic        exc_flush;
    logic [31:0] exc_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } out_t;

    logic [31:0] exp_req_q[$];
    out_t        exp_out_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int data_delay = 1;
    int last_hs_cyc = 0;
    int last_hs_delay = 1;
    logic prev_valid = 1'b0;

    logic        slv_busy;
    int          slv_cnt;
    logic [31:0] slv_addr;

    if_stage #(.RESET_PC(32'hBFC00000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel),
        .id_allowin   (id_allowin),
        .id_br_fire   (id_br_fire),
        .id_jump      (id_jump),
        .id_target    (id_target),
        .exc_flush    (exc_flush),
        .exc_pc       (exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic pushOut(input logic [31:0] pc, input logic adel);
        out_t e;
        e.pc   = pc;
        e.inst = adel ? 32'd0 : memWord(pc);
        e.adel = adel;
        exp_out_q.push_back(e);
    endtask

    // Instruction slave: accepts addresses immediately, answers after
    // data_delay cycles (1 = data_ok in the cycle after the handshake).
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slv_busy     <= 1'b0;
            slv_cnt      <= 0;
            slv_addr     <= 32'd0;
            inst_data_ok <= 1'b0;
            inst_rdata   <= 32'd0;
        end else begin
            inst_data_ok <= 1'b0;
            if (slv_busy) begin
                if (slv_cnt <= 1) begin
                    inst_data_ok <= 1'b1;
                    inst_rdata   <= memWord(slv_addr);
                    slv_busy     <= 1'b0;
                end else begin
                    slv_cnt <= slv_cnt - 1;
                end
            end
            if (inst_req && inst_addr_ok) begin
                if (data_delay <= 1) begin
                    inst_data_ok <= 1'b1;
                    inst_rdata   <= memWord(inst_addr);
                end else begin
                    slv_busy <= 1'b1;
                    slv_addr <= inst_addr;
                    slv_cnt  <= data_delay - 1;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (inst_req) begin
                checkOutput("one_outstanding", {31'd0, slv_busy | inst_data_ok}, 32'd0);
            end
            if (inst_req && inst_addr_ok) begin
                if (exp_req_q.size() == 0) begin
                    failNow("unexpected_request");
                    $display("[TB]   request address %h", inst_addr);
                end else begin
                    checkOutput("req_addr", inst_addr, exp_req_q.pop_front());
                end
                last_hs_cyc   = cyc;
                last_hs_delay = data_delay;
            end
            if (if_valid && !prev_valid && !if_adel) begin
                checkOutput("valid_latency", cyc - last_hs_cyc, last_hs_delay + 1);
            end
            prev_valid = if_valid;
            if (if_valid && id_allowin && !exc_flush) begin
                if (exp_out_q.size() == 0) begin
                    failNow("unexpected_transfer");
                    $display("[TB]   transfer pc %h", if_pc);
                end else begin
                    out_t e;
                    e = exp_out_q.pop_front();
                    checkOutput("out_pc", if_pc, e.pc);
                    checkOutput("out_inst", if_inst, e.inst);
                    checkOutput("out_adel", {31'd0, if_adel}, {31'd0, e.adel});
                end
            end
        end
    end

    // Drive a one-cycle pulse of the branch / flush inputs.
    task automatic applyStimulus(input logic br, input logic jmp, input logic [31:0] tgt,
                                 input logic fl, input logic [31:0] epc);
        id_br_fire = br;
        id_jump    = jmp;
        id_target  = tgt;
        exc_flush  = fl;
        exc_pc     = epc;
        @(posedge clk); #1;
        id_br_fire = 1'b0;
        id_jump    = 1'b0;
        exc_flush  = 1'b0;
    endtask

    task automatic waitValid();
        int n = 0;
        while (!if_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!if_valid) failNow("valid_timeout");
    endtask

    // Accept the next buffered entry, optionally with a taken branch or a
    // flush in the same cycle.
    task automatic acceptOne(input logic br, input logic [31:0] tgt,
                             input logic fl, input logic [31:0] epc);
        waitValid();
        if (if_valid) begin
            id_allowin = 1'b1;
            id_br_fire = br;
            id_jump    = br;
            id_target  = tgt;
            exc_flush  = fl;
            exc_pc     = epc;
            @(posedge clk); #1;
            id_allowin = 1'b0;
            id_br_fire = 1'b0;
            id_jump    = 1'b0;
            exc_flush  = 1'b0;
        end
    endtask

    initial begin
        resetn       = 1'b0;
        inst_addr_ok = 1'b1;
        id_allowin   = 1'b0;
        id_br_fire   = 1'b0;
        id_jump      = 1'b0;
        id_target    = 32'd0;
        exc_flush    = 1'b0;
        exc_pc       = 32'd0;

        foreach (exp_req_q[i]) exp_req_q.delete(i);
        exp_req_q = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00100,
                      32'hBFC00104, 32'hBFC00200, 32'hBFC00204, 32'hBFC00380,
                      32'hBFC00384, 32'hBFC00500, 32'hBFC00504, 32'hBFC00700,
                      32'hBFC00704};
        pushOut(32'hBFC00000, 1'b0);
        pushOut(32'hBFC00004, 1'b0);
        pushOut(32'hBFC00008, 1'b0);
        pushOut(32'hBFC00100, 1'b0);
        pushOut(32'hBFC00104, 1'b0);
        pushOut(32'hBFC00200, 1'b0);
        pushOut(32'hBFC00204, 1'b0);
        pushOut(32'hBFC00102, 1'b1);
        pushOut(32'hBFC00380, 1'b0);
        pushOut(32'hBFC00500, 1'b0);
        pushOut(32'hBFC00700, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_inst_req", {31'd0, inst_req}, 32'd0);
        checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_inst", if_inst, 32'd0);
        checkOutput("rst_if_adel", {31'd0, if_adel}, 32'd0);
        checkOutput("rst_inst_addr", inst_addr, 32'hBFC00000);
        checkOutput("inst_wr", {31'd0, inst_wr}, 32'd0);
        checkOutput("inst_size", {30'd0, inst_size}, 32'd2);
        resetn = 1'b1;

        $display("[TB] sequential fetch");
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] decode stall");
        waitValid();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_pc", if_pc, 32'hBFC00004);
            checkOutput("stall_inst", if_inst, memWord(32'hBFC00004));
            checkOutput("stall_no_req", {31'd0, inst_req}, 32'd0);
            @(posedge clk); #1;
        end
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] branch during delay-slot fetch");
        applyStimulus(1'b1, 1'b1, 32'hBFC00100, 1'b0, 32'd0);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] branch coincident with transfer");
        acceptOne(1'b1, 32'hBFC00200, 1'b0, 32'd0);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] misaligned target");
        applyStimulus(1'b1, 1'b1, 32'hBFC00102, 1'b0, 32'd0);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);
        waitValid();
        checkOutput("adel_no_req", {31'd0, inst_req}, 32'd0);
        checkOutput("adel_flag", {31'd0, if_adel}, 32'd1);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] flush coincident with transfer");
        acceptOne(1'b0, 32'd0, 1'b1, 32'hBFC00380);
        applyStimulus(1'b1, 1'b0, 32'hDEAD0000, 1'b0, 32'd0);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] flush in WAIT with late data");
        data_delay = 3;
        applyStimulus(1'b1, 1'b1, 32'hBFC00600, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00500);
        data_delay = 1;
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] flush coincident with data_ok");
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC00700);
        acceptOne(1'b0, 32'd0, 1'b0, 32'd0);

        repeat (6) @(posedge clk);
        #1;
        checkOutput("req_queue_empty", exp_req_q.size(), 32'd0);
        checkOutput("out_queue_empty", exp_out_q.size(), 32'd0);
        checkOutput("final_hold_pc", if_pc, 32'hBFC00704);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
